noc_flit_sink: RTL and testbench

Ejection endpoint for one router link port. Receives flits from a router output port (the data/dest/is_tail/send side of the credit-based link), buffers them, and presents them as an AXI-Stream master. Returns one credit to the upstream router per flit drained. It is the receive-side counterpart of the router link transmitter and lets a NoC link be terminated directly in user logic without a full router_wrap.

---
 rtl/noc_flit_sink.sv | 139 +++++++++++++
 tb/tb_noc_flit_sink.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_sink.sv
// NoC link ejection endpoint: buffers incoming flits and presents them as an
// AXI-Stream master, returning one credit upstream per flit drained.

module noc_flit_sink_entry #(
    parameter int W = 1
) (
    input  logic         clk_noc,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (we) q_d = d;
    end

    always_ff @(posedge clk_noc or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

module noc_flit_sink #(
    parameter int FLIT_WIDTH   = 32,
    parameter int TID_WIDTH    = 2,
    parameter int TDEST_WIDTH  = 4,
    parameter int DEST_WIDTH   = TID_WIDTH + TDEST_WIDTH,
    parameter int BUFFER_DEPTH = 4,
    parameter int PTR_WIDTH    = 2
) (
    input  logic                   clk_noc,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [FLIT_WIDTH-1:0]  axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TID_WIDTH-1:0]   axis_out_tid,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic                   overflow_err,
    output logic [15:0]            pkt_count
);
    localparam int ENT_W = FLIT_WIDTH + DEST_WIDTH + 1;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tail;
    } flit_t;

    logic [PTR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
    logic [PTR_WIDTH:0]   count_d, count_q;
    logic                 credit_d, credit_q;
    logic                 overflow_d, overflow_q;
    logic [15:0]          pkt_d, pkt_q;

    logic [BUFFER_DEPTH-1:0][ENT_W-1:0] ent_q;
    logic [BUFFER_DEPTH-1:0]            ent_we;
    flit_t                              wr_flit, head;
    logic                               full, pop, push_ok;

    assign wr_flit = '{data: data_in, dest: dest_in, tail: is_tail_in};
    assign head    = flit_t'(ent_q[rd_ptr_q]);

    // Depth is a power of two, so the count MSB alone marks the full state.
    assign full    = count_q[PTR_WIDTH];
    assign pop     = (count_q != '0) && axis_out_tready;
    assign push_ok = send_in && (!full || pop);

    genvar i;
    generate
        for (i = 0; i < BUFFER_DEPTH; i++) begin : g_ent
            assign ent_we[i] = push_ok && (wr_ptr_q == PTR_WIDTH'(i));
            noc_flit_sink_entry #(.W(ENT_W)) u_ent (
                .clk_noc (clk_noc),
                .rst     (rst),
                .we      (ent_we[i]),
                .d       (wr_flit),
                .q       (ent_q[i])
            );
        end
    endgenerate

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        credit_d   = pop;
        overflow_d = overflow_q;
        pkt_d      = pkt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A dropped push leaves every pointer alone; only the sticky flag moves.
        if (send_in && full && !pop) overflow_d = 1'b1;
        if (pop && head.tail)        pkt_d = pkt_q + 16'd1;
    end

    always_ff @(posedge clk_noc or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
            pkt_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
            pkt_q      <= pkt_d;
        end
    end

    assign credit_out      = credit_q;
    assign axis_out_tvalid = (count_q != '0);
    assign axis_out_tdata  = head.data;
    assign axis_out_tlast  = head.tail;
    assign axis_out_tid    = head.dest[DEST_WIDTH-1:TDEST_WIDTH];
    assign axis_out_tdest  = head.dest[TDEST_WIDTH-1:0];
    assign overflow_err    = overflow_q;
    assign pkt_count       = pkt_q;
endmodule

// File: tb/tb_noc_flit_sink.sv
// Directed bench for noc_flit_sink: a cycle table plus hand-written reset,
// overflow and credit-gated streaming sequences.

module tb_noc_flit_sink;
    logic        clk_noc = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic [5:0]  dest_in = '0;
    logic        is_tail_in = 1'b0;
    logic        send_in = 1'b0;
    logic        credit_out;
    logic        axis_out_tvalid;
    logic        axis_out_tready = 1'b0;
    logic [31:0] axis_out_tdata;
    logic        axis_out_tlast;
    logic [1:0]  axis_out_tid;
    logic [3:0]  axis_out_tdest;
    logic        overflow_err;
    logic [15:0] pkt_count;

    int n_vec = 0;
    int n_err = 0;

    noc_flit_sink dut (
        .clk_noc         (clk_noc),
        .rst             (rst),
        .data_in         (data_in),
        .dest_in         (dest_in),
        .is_tail_in      (is_tail_in),
        .send_in         (send_in),
        .credit_out      (credit_out),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tid    (axis_out_tid),
        .axis_out_tdest  (axis_out_tdest),
        .overflow_err    (overflow_err),
        .pkt_count       (pkt_count)
    );

    always #5 clk_noc = ~clk_noc;

    typedef struct {
        logic        send;
        logic [31:0] data;
        logic [5:0]  dest;
        logic        tail;
        logic        tready;
        logic        e_vld;
        logic [31:0] e_data;
        logic        e_last;
        logic [1:0]  e_tid;
        logic [3:0]  e_tdest;
        logic        e_cred;
        logic [15:0] e_pkt;
    } vec_t;

    vec_t tv[23];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] d, input logic [5:0] de,
                         input logic t, input logic r);
        send_in = s; data_in = d; dest_in = de; is_tail_in = t; axis_out_tready = r;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        @(negedge clk_noc);
        rst = 1'b1;
        @(negedge clk_noc);
        rst = 1'b0;
        @(posedge clk_noc);
        #1;
    endtask

    initial begin
        logic [31:0] got[$];
        int          creds, cyc, sent, rcvd, up_cred;
        logic        pop_s;
        logic [31:0] pop_d;

        tv[0]  = '{1, 32'hDEADBEEF, 6'b10_0101, 1, 1,  1, 32'hDEADBEEF, 1, 2, 5,  0, 0};
        tv[1]  = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  1, 1};
        tv[2]  = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 1};
        tv[3]  = '{1, 1, 0, 0, 0,  1, 1, 0, 0, 0,  0, 1};
        tv[4]  = '{1, 2, 0, 0, 0,  1, 1, 0, 0, 0,  0, 1};
        tv[5]  = '{1, 3, 0, 0, 0,  1, 1, 0, 0, 0,  0, 1};
        tv[6]  = '{1, 4, 0, 1, 0,  1, 1, 0, 0, 0,  0, 1};
        tv[7]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 0,  0, 1};
        tv[8]  = '{0, 0, 0, 0, 1,  1, 2, 0, 0, 0,  1, 1};
        tv[9]  = '{0, 0, 0, 0, 1,  1, 3, 0, 0, 0,  1, 1};
        tv[10] = '{0, 0, 0, 0, 1,  1, 4, 1, 0, 0,  1, 1};
        tv[11] = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  1, 2};
        tv[12] = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 2};
        tv[13] = '{1, 1, 0, 0, 0,  1, 1, 0, 0, 0,  0, 2};
        tv[14] = '{1, 2, 0, 0, 0,  1, 1, 0, 0, 0,  0, 2};
        tv[15] = '{1, 3, 0, 0, 0,  1, 1, 0, 0, 0,  0, 2};
        tv[16] = '{1, 4, 0, 1, 0,  1, 1, 0, 0, 0,  0, 2};
        tv[17] = '{1, 5, 6'b01_1010, 1, 1,  1, 2, 0, 0, 0,  1, 2};
        tv[18] = '{0, 0, 0, 0, 1,  1, 3, 0, 0, 0,  1, 2};
        tv[19] = '{0, 0, 0, 0, 1,  1, 4, 1, 0, 0,  1, 2};
        tv[20] = '{0, 0, 0, 0, 1,  1, 5, 1, 1, 10, 1, 3};
        tv[21] = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  1, 4};
        tv[22] = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 4};

        // Reset asserted asynchronously with three flits held under backpressure
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h100 + k, 6'h3F, 1, 0);
            @(posedge clk_noc); #1;
        end
        drive(0, 0, 0, 0, 0);
        chk("pre_rst_tvalid", 0, axis_out_tvalid, 1);
        @(negedge clk_noc); #1;
        rst = 1'b1;
        #1;
        chk("rst_tvalid", 0, axis_out_tvalid, 0);
        chk("rst_tdata", 0, axis_out_tdata, 0);
        chk("rst_tlast", 0, axis_out_tlast, 0);
        chk("rst_tid", 0, axis_out_tid, 0);
        chk("rst_tdest", 0, axis_out_tdest, 0);
        chk("rst_credit", 0, credit_out, 0);
        chk("rst_ovf", 0, overflow_err, 0);
        chk("rst_pkt", 0, pkt_count, 0);
        @(negedge clk_noc);
        rst = 1'b0;
        repeat (2) @(posedge clk_noc);
        #1;
        chk("post_rst_tvalid", 0, axis_out_tvalid, 0);

        // Table: single flit, fill/backpressure/drain, full with push+pop
        for (int i = 0; i < 23; i++) begin
            drive(tv[i].send, tv[i].data, tv[i].dest, tv[i].tail, tv[i].tready);
            @(posedge clk_noc); #1;
            chk("tvalid", i, axis_out_tvalid, tv[i].e_vld);
            chk("credit", i, credit_out, tv[i].e_cred);
            chk("ovf", i, overflow_err, 0);
            chk("pkt", i, pkt_count, tv[i].e_pkt);
            if (tv[i].e_vld) begin
                chk("tdata", i, axis_out_tdata, tv[i].e_data);
                chk("tlast", i, axis_out_tlast, tv[i].e_last);
                chk("tid", i, axis_out_tid, tv[i].e_tid);
                chk("tdest", i, axis_out_tdest, tv[i].e_tdest);
            end
        end

        // Overflow: push into a full buffer with no pop is dropped
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h11 + k, 0, (k == 3), 0);
            @(posedge clk_noc); #1;
        end
        drive(1, 32'h9, 0, 1, 0);
        @(posedge clk_noc); #1;
        chk("ovf_set", 0, overflow_err, 1);
        chk("ovf_head", 0, axis_out_tdata, 32'h11);
        drive(0, 0, 0, 0, 1);
        creds = 0;
        for (int c = 0; c < 12; c++) begin
            if (axis_out_tvalid) got.push_back(axis_out_tdata);
            @(posedge clk_noc); #1;
            creds += int'(credit_out);
        end
        chk("ovf_drain_n", 0, got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk("ovf_drain_data", k, got[k], 32'h11 + k);
        chk("ovf_credits", 0, creds, 4);
        chk("ovf_sticky", 0, overflow_err, 1);
        chk("ovf_pkt", 0, pkt_count, 5);

        // Streaming: 100 x 3-flit packets, credit-gated sender, random tready
        do_reset();
        chk("stream_ovf_clr", 0, overflow_err, 0);
        sent = 0; rcvd = 0; creds = 0; up_cred = 4; cyc = 0;
        while (rcvd < 300 && cyc < 5000) begin
            if (sent < 300 && up_cred > 0)
                drive(1, 32'hA500_0000 + sent, 6'(sent), (sent % 3 == 2), 1'b0);
            else
                drive(0, 0, 0, 0, 0);
            axis_out_tready = ($urandom_range(0, 3) != 0);
            pop_s = axis_out_tvalid && axis_out_tready;
            pop_d = axis_out_tdata;
            @(posedge clk_noc);
            if (send_in) begin
                sent++;
                up_cred--;
            end
            if (pop_s) begin
                chk("stream_data", rcvd, pop_d, 32'hA500_0000 + rcvd);
                rcvd++;
            end
            #1;
            if (credit_out) begin
                creds++;
                up_cred++;
            end
            cyc++;
        end
        chk("stream_timeout", 0, (cyc < 5000), 1);
        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_noc); #1;
            creds += int'(credit_out);
        end
        chk("stream_pkt", 0, pkt_count, 100);
        chk("stream_credits", 0, creds, 300);
        chk("stream_ovf", 0, overflow_err, 0);
        chk("stream_empty", 0, axis_out_tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
